// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit framer (start, LSB-first data, optional parity, stop)
// with a per-frame captured bit-period prescaler.
module uart_tx_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_data_valid,
  input  logic [DATA_WIDTH-1:0]     i_p_data,
  input  logic                      i_par_en,
  input  logic                      i_par_typ,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_tx_out,
  output logic                      o_busy
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  logic [2:0]                state_q, state_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d, np_q, np_d;
  logic                      par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic                      tx_q, tx_d, busy_q, busy_d;
  logic                      tick;
  assign tick     = pre_cnt_q == np_q - PRESCALE_WIDTH'(1);
  assign o_tx_out = tx_q;
  assign o_busy   = busy_q;
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    np_d      = np_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_WIDTH'(1);
    case (state_q)
      IDLE: begin
        pre_cnt_d = '0;
        if (i_data_valid) begin
          state_d   = START;
          shift_d   = i_p_data;
          par_en_d  = i_par_en;
          par_bit_d = i_par_typ ^ (^i_p_data);
          np_d      = (i_prescale == '0) ? PRESCALE_WIDTH'(1) : i_prescale;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: if (tick) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        tx_d      = shift_q[0];
      end
      DATA: if (tick) begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        // last data bit hands over to parity or stop; otherwise present the next bit
        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
          state_d = par_en_q ? PARITY : STOP;
          tx_d    = par_en_q ? par_bit_q : 1'b1;
        end else begin
          tx_d = shift_q[1];
        end
      end
      PARITY: if (tick) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (tick) begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      pre_cnt_q <= '0;
      np_q      <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      np_q      <= np_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit side of the UART link: accepts one parallel word per handshake and shifts it out as a standard asynchronous frame.
- Frame order: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- Bit timing comes from an internal prescale counter driven by i_clk. The block pairs with the RX deserializer, which rebuilds words from LSB-first sampled bits.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_WIDTH, 6, width of the i_prescale bit-period input.

Ports:
- i_clk  input  1  system clock; all logic on posedge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_data_valid  input  1  request to send i_p_data; sampled only when o_busy=0.
- i_p_data  input  DATA_WIDTH  parallel word to transmit.
- i_par_en  input  1  1 = append parity bit.
- i_par_typ  input  1  0 = even parity, 1 = odd parity.
- i_prescale  input  PRESCALE_WIDTH  i_clk cycles per serial bit; 0 treated as 1.
- o_tx_out  output  1  serial line, registered, idles high.
- o_busy  output  1  registered; high while a frame is in flight.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - o_tx_out=1, o_busy=0, FSM=IDLE.
  - Shift register, bit counter and prescale counter cleared.
  - No partial frame resumes after reset release.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx_out=1, o_busy=0.
  - At a posedge with i_data_valid=1, capture i_p_data, i_par_en, i_par_typ and i_prescale (Np=max(i_prescale,1)).
  - Parity is computed from the captured word: even = XOR of all data bits; odd = its inverse.
  - From that same edge: FSM=START, o_tx_out=0, o_busy=1.
- Bit timing:
  - Every state except IDLE holds o_tx_out for exactly Np clocks.
  - The prescale counter counts 0..Np-1; the state or bit advances on the edge where the counter equals Np-1.
- START: drives 0 for Np clocks, then goes to DATA with bit index 0.
- DATA:
  - Drives captured bit[index] (LSB first, shift-right register).
  - After DATA_WIDTH bits, goes to PARITY if parity was captured enabled, else to STOP.
- PARITY: drives the computed parity bit for Np clocks, then goes to STOP.
- STOP:
  - Drives 1 for Np clocks, then goes to IDLE; o_busy falls on that same edge.
  - i_data_valid during STOP is ignored, so there is at least one IDLE clock between frames (line stays high).
- Frame length: (2 + DATA_WIDTH + P) x Np clocks, where P = captured i_par_en. o_busy is high for exactly that many clocks.
- i_data_valid while o_busy=1: ignored. No queuing and no corruption of the current frame.
- Changes to i_p_data, i_par_en, i_par_typ or i_prescale mid-frame: no effect until the next accept.
- i_data_valid held continuously high: a new frame starts on every IDLE clock, i.e. back-to-back frames separated by one idle clock.
- Glitch-free line: o_tx_out comes directly from a flop, and changes only on bit boundaries and on accept.

Test Plan:
- Basic frame: DATA_WIDTH=8, i_prescale=4, i_par_en=0, send 0xA5 → o_tx_out holds 0,1,0,1,0,0,1,0,1,1 for 4 clocks each. o_busy high for exactly 40 clocks, then o_tx_out=1, o_busy=0.
- Odd parity: 0x00, i_par_en=1, i_par_typ=1, i_prescale=2 → eight 0 data bits, then parity bit 1, then stop 1. o_busy high for 22 clocks.
- Even parity: 0x07, i_par_en=1, i_par_typ=0, i_prescale=3 → data 1,1,1,0,0,0,0,0, parity 1. Repeat with 0x03 → parity 0.
- Busy rejection and config latching: start 0x3C with i_prescale=4. At clock 10 pulse i_data_valid with 0xFF and change i_prescale to 8 → 0x3C frame unchanged at 4 clocks per bit, no second frame. Hold i_data_valid with 0x81 after o_busy falls → next frame starts after exactly one idle clock.
- Reset mid-frame: assert i_rst_n=0 during data bit 3 of 0x55 → o_tx_out=1 and o_busy=0 immediately (asynchronous). After release with no i_data_valid, the line stays 1 for 100 clocks.
- Prescale edge: i_prescale=0 and i_prescale=1, send 0xF0 → each bit lasts 1 clock, o_busy high for 10 clocks. Continuous i_data_valid gives frames 11 clocks apart.
